// File: rtl/rfid_tx_pkg.sv
// Shared types for the RFID backscatter transmit path: FSM states, FM0 half-bit phase
// and the default FIFO word width.
package rfid_tx_pkg;

   localparam int DATA_W_DEF = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      DUMMY,
      DONE
   } state_e;

   typedef enum logic {
      FIRST,
      SECOND
   } phase_e;

endpackage

// File: rtl/fm0_encoder.sv
// FM0 level register: the level inverts at every bit boundary, and also mid-bit for a 0.
// During the end-of-signalling dummy-1 the mid-bit inversion is suppressed.
module fm0_encoder
   import rfid_tx_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic phase,
   input  logic bit_val,
   input  logic dummy,
   input  logic clear,
   output logic level
);

   logic level_q, level_d;

   always_comb begin
      level_d = level_q;
      if (clear) begin
         level_d = 1'b0;
      end else if (tick) begin
         if (phase == FIRST) begin
            level_d = ~level_q;
         end else if (!dummy && !bit_val) begin
            level_d = ~level_q;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level_q <= 1'b0;
      end else begin
         level_q <= level_d;
      end
   end

   assign level = level_q;

endmodule

// File: rtl/fifo_fm0_tx.sv
// Drains the TX FIFO one word at a time and sends it MSB first as FM0, then the dummy-1,
// then pulses done. Words are chained with no gap while the FIFO stays non-empty.
module fifo_fm0_tx
   import rfid_tx_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              start,
   input  logic              half_tick,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_read,
   output logic              fm0_out,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   state_e            state_q, state_d;
   phase_e            phase_q, phase_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              enc_tick;

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      fifo_read = 1'b0;
      if (!en) begin
         state_d = IDLE;
         phase_d = FIRST;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start && !fifo_empty) begin
                  state_d = LOAD;
               end
            end
            LOAD: begin
               // The head word can vanish between request and pop; fall back quietly.
               if (!fifo_empty) begin
                  fifo_read = 1'b1;
                  shreg_d   = fifo_data;
                  bit_cnt_d = '0;
                  phase_d   = FIRST;
                  state_d   = SHIFT;
               end else begin
                  state_d = IDLE;
               end
            end
            SHIFT: begin
               if (half_tick) begin
                  if (phase_q == FIRST) begin
                     phase_d = SECOND;
                  end else begin
                     phase_d   = FIRST;
                     shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
                     bit_cnt_d = bit_cnt_q + 1'b1;
                     if (bit_cnt_q == LAST_BIT) begin
                        // Pop the next word on the very tick that ends this one.
                        if (!fifo_empty) begin
                           fifo_read = 1'b1;
                           shreg_d   = fifo_data;
                           bit_cnt_d = '0;
                        end else begin
                           state_d = DUMMY;
                        end
                     end
                  end
               end
            end
            DUMMY: begin
               if (half_tick) begin
                  if (phase_q == FIRST) begin
                     phase_d = SECOND;
                  end else begin
                     phase_d = FIRST;
                     state_d = DONE;
                  end
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         phase_q   <= FIRST;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   assign enc_tick = en && half_tick && ((state_q == SHIFT) || (state_q == DUMMY));

   fm0_encoder u_enc (
      .clk     (clk),
      .reset   (reset),
      .tick    (enc_tick),
      .phase   (phase_q),
      .bit_val (shreg_q[DATA_W-1]),
      .dummy   (state_q == DUMMY),
      .clear   (!en),
      .level   (fm0_out)
   );

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);

endmodule

// File: tb/tb_fifo_fm0_tx.sv
// Randomised bench for fifo_fm0_tx: a FIFO model feeds the DUT and every half-bit level is
// checked against an FM0 reference built directly from the byte values.
module tb_fifo_fm0_tx;

   logic clk = 1'b0;
   logic reset, en, start, half_tick, flush;
   logic fifo_empty, fifo_read, fm0_out, busy, done;
   logic [7:0] fifo_data;

   logic [7:0] mem [0:63];
   int rd = 0, wr = 0, pops = 0, rd_viol = 0;
   int checks = 0, errors = 0;
   logic exp_h [0:255];
   logic obs_h [0:255];
   logic [7:0] frm [0:15];
   logic exp_lvl;

   fifo_fm0_tx #(.DATA_W(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .start      (start),
      .half_tick  (half_tick),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_read  (fifo_read),
      .fm0_out    (fm0_out),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   assign fifo_empty = (rd == wr);
   assign fifo_data  = mem[rd[5:0]];

   always @(posedge clk) begin
      if (flush) rd <= wr;
      else if (fifo_read && !fifo_empty) rd <= rd + 1;
      if (fifo_read) pops <= pops + 1;
      if (fifo_read && fifo_empty) rd_viol <= rd_viol + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] v);
      mem[wr[5:0]] = v;
      wr = wr + 1;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   // FM0 reference: invert at each bit start, invert mid-bit for a 0, then dummy-1.
   task automatic build_expected(input int nb, input logic lvl0, output int ne);
      logic l;
      l  = lvl0;
      ne = 0;
      for (int i = 0; i < nb; i++) begin
         for (int b = 7; b >= 0; b--) begin
            l = ~l;
            exp_h[ne] = l;
            ne++;
            if (frm[i][b] == 1'b0) l = ~l;
            exp_h[ne] = l;
            ne++;
         end
      end
      l = ~l;
      exp_h[ne] = l;
      ne++;
      exp_h[ne] = l;
      ne++;
   endtask

   task automatic start_frame();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
   endtask

   // Issues half ticks until done is seen or max_h ticks have been sent.
   task automatic run_ticks(input int max_h, input int sp, input int refill_at,
                            input logic [7:0] refill_val, input logic noise,
                            output int nh, output int nd);
      int s;
      nh = 0;
      nd = 0;
      for (int h = 0; h < max_h; h++) begin
         s = (sp == 0) ? int'($urandom_range(2, 5)) : sp;
         for (int k = 1; k < s; k++) begin
            start = noise && ($urandom_range(0, 3) == 0);
            step();
            start = 1'b0;
            if (done) nd++;
         end
         if (h == refill_at) push(refill_val);
         half_tick = 1'b1;
         step();
         half_tick = 1'b0;
         obs_h[nh] = fm0_out;
         nh++;
         if (done) begin
            nd++;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; en = 1'b1; start = 1'b0; half_tick = 1'b0; flush = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({fm0_out, busy, done, fifo_read} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outputs: got %b want 0000", {fm0_out, busy, done, fifo_read});
      end
      reset = 1'b0;
      step();
      exp_lvl = 1'b0;
   endtask

   task automatic test_single_byte();
      logic [17:0] aa_seq;
      int nh, nd, p0;
      aa_seq = 18'b110100101101001011;
      push(8'hAA);
      p0 = pops;
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || fifo_read !== 1'b1) begin
         errors++;
         $display("FAIL load_cycle: busy=%b fifo_read=%b want 1 1", busy, fifo_read);
      end
      step();
      run_ticks(40, 20, -1, 8'h00, 1'b0, nh, nd);
      checks++;
      if (nh !== 18) begin
         errors++;
         $display("FAIL single_len: got %0d halves want 18", nh);
      end
      for (int i = 0; i < 18 && i < nh; i++) begin
         checks++;
         if (obs_h[i] !== aa_seq[17-i]) begin
            errors++;
            $display("FAIL single_half%0d: got %b want %b", i, obs_h[i], aa_seq[17-i]);
         end
      end
      checks++;
      if (nd !== 1 || pops - p0 !== 1) begin
         errors++;
         $display("FAIL single_counts: done=%0d reads=%0d want 1 1", nd, pops - p0);
      end
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || fm0_out !== 1'b1) begin
         errors++;
         $display("FAIL single_after: busy=%b done=%b fm0=%b want 0 0 1", busy, done, fm0_out);
      end
      exp_lvl = 1'b1;
   endtask

   task automatic test_back_to_back();
      int nh, nd, ne, p0;
      frm[0] = 8'h00; frm[1] = 8'hFF;
      push(8'h00); push(8'hFF);
      build_expected(2, exp_lvl, ne);
      p0 = pops;
      start_frame();
      run_ticks(60, 0, -1, 8'h00, 1'b0, nh, nd);
      checks++;
      if (nh !== 34 || nh !== ne) begin
         errors++;
         $display("FAIL b2b_len: got %0d halves want 34", nh);
      end
      for (int i = 0; i < ne && i < nh; i++) begin
         checks++;
         if (obs_h[i] !== exp_h[i]) begin
            errors++;
            $display("FAIL b2b_half%0d: got %b want %b", i, obs_h[i], exp_h[i]);
         end
      end
      checks++;
      if (nd !== 1 || pops - p0 !== 2) begin
         errors++;
         $display("FAIL b2b_counts: done=%0d reads=%0d want 1 2", nd, pops - p0);
      end
      exp_lvl = exp_h[ne-1];
      step();
   endtask

   task automatic test_random_frames();
      int nh, nd, ne, nb, p0, bad;
      for (int f = 0; f < 5; f++) begin
         nb = int'($urandom_range(1, 4));
         for (int i = 0; i < nb; i++) begin
            frm[i] = 8'($urandom);
            push(frm[i]);
         end
         build_expected(nb, exp_lvl, ne);
         p0 = pops;
         start_frame();
         run_ticks(16 * nb + 10, 0, -1, 8'h00, 1'b1, nh, nd);
         checks++;
         if (nh !== 16 * nb + 2) begin
            errors++;
            $display("FAIL rand%0d_len: got %0d halves want %0d", f, nh, 16 * nb + 2);
         end
         bad = 0;
         for (int i = 0; i < ne && i < nh; i++) if (obs_h[i] !== exp_h[i]) bad++;
         checks++;
         if (bad !== 0) begin
            errors++;
            $display("FAIL rand%0d_levels: got %0d wrong halves want 0", f, bad);
         end
         checks++;
         if (nd !== 1 || pops - p0 !== nb) begin
            errors++;
            $display("FAIL rand%0d_counts: done=%0d reads=%0d want 1 %0d", f, nd, pops - p0, nb);
         end
         exp_lvl = exp_h[ne-1];
         step();
      end
   endtask

   task automatic test_empty_start();
      int bad;
      do_flush();
      start = 1'b1;
      step();
      start = 1'b0;
      bad = 0;
      for (int c = 0; c < 8; c++) begin
         half_tick = (c % 3 == 1);
         step();
         half_tick = 1'b0;
         if (busy !== 1'b0 || fifo_read !== 1'b0 || done !== 1'b0 || fm0_out !== exp_lvl) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL empty_start: got %0d bad cycles want 0", bad);
      end
   endtask

   task automatic test_abort();
      int nh, nd, ne, p0, bad, ndone;
      frm[0] = 8'h5C;
      push(8'h5C); push(8'h33);
      build_expected(1, exp_lvl, ne);
      p0 = pops;
      start_frame();
      run_ticks(7, 3, -1, 8'h00, 1'b0, nh, nd);
      bad = 0;
      for (int i = 0; i < 7; i++) if (obs_h[i] !== exp_h[i]) bad++;
      checks++;
      if (nh !== 7 || bad !== 0) begin
         errors++;
         $display("FAIL abort_prefix: got %0d halves %0d wrong want 7 0", nh, bad);
      end
      en = 1'b0;
      step();
      checks++;
      if (fm0_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_outputs: fm0=%b busy=%b done=%b want 0 0 0", fm0_out, busy, done);
      end
      ndone = 0;
      for (int c = 0; c < 60; c++) begin
         if (c == 10) en = 1'b1;
         half_tick = (c % 3 == 2);
         step();
         half_tick = 1'b0;
         if (done) ndone++;
      end
      checks++;
      if (pops - p0 !== 1 || ndone !== 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_after: reads=%0d done=%0d busy=%b want 1 0 0", pops - p0, ndone, busy);
      end
      do_flush();
      exp_lvl = 1'b0;
   endtask

   task automatic test_refill_race();
      int nh, nd, ne, p0, bad;
      frm[0] = 8'($urandom);
      frm[1] = 8'($urandom);
      push(frm[0]);
      build_expected(2, exp_lvl, ne);
      p0 = pops;
      start_frame();
      run_ticks(60, 0, 15, frm[1], 1'b0, nh, nd);
      bad = 0;
      for (int i = 0; i < ne && i < nh; i++) if (obs_h[i] !== exp_h[i]) bad++;
      checks++;
      if (nh !== 34 || bad !== 0) begin
         errors++;
         $display("FAIL refill_levels: got %0d halves %0d wrong want 34 0", nh, bad);
      end
      checks++;
      if (nd !== 1 || pops - p0 !== 2) begin
         errors++;
         $display("FAIL refill_counts: done=%0d reads=%0d want 1 2", nd, pops - p0);
      end
      exp_lvl = exp_h[ne-1];
      step();
   endtask

   task automatic test_reset_mid_frame();
      int nh, nd, ne, p0, bad;
      frm[0] = 8'($urandom);
      push(frm[0]);
      build_expected(1, exp_lvl, ne);
      start_frame();
      run_ticks(17, 3, -1, 8'h00, 1'b0, nh, nd);
      checks++;
      if (nh !== 17 || nd !== 0 || obs_h[16] !== exp_h[16] || busy !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre: halves=%0d done=%0d lvl=%b busy=%b want 17 0 %b 1",
                  nh, nd, obs_h[16], busy, exp_h[16]);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({fm0_out, busy, done, fifo_read} !== 4'b0000) begin
         errors++;
         $display("FAIL rst_async: got %b want 0000", {fm0_out, busy, done, fifo_read});
      end
      reset = 1'b0;
      step();
      exp_lvl = 1'b0;
      frm[0] = 8'($urandom);
      push(frm[0]);
      build_expected(1, exp_lvl, ne);
      p0 = pops;
      start_frame();
      run_ticks(30, 0, -1, 8'h00, 1'b0, nh, nd);
      bad = 0;
      for (int i = 0; i < ne && i < nh; i++) if (obs_h[i] !== exp_h[i]) bad++;
      checks++;
      if (nh !== 18 || bad !== 0 || nd !== 1 || pops - p0 !== 1) begin
         errors++;
         $display("FAIL rst_restart: halves=%0d wrong=%0d done=%0d reads=%0d want 18 0 1 1",
                  nh, bad, nd, pops - p0);
      end
      step();
   endtask

   task automatic test_no_read_when_empty();
      checks++;
      if (rd_viol !== 0) begin
         errors++;
         $display("FAIL read_while_empty: got %0d want 0", rd_viol);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_random_frames();
      test_empty_start();
      test_abort();
      test_refill_race();
      test_reset_mid_frame();
      test_no_read_when_empty();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
